// File: rtl/axi4_lite_write_arbiter.sv
// Shares one AXI4-Lite write slave between NUM_REQ masters, holding each grant for a full AW+W+B transaction.
// Build option: define WR_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (default is round-robin).
module axi4_lite_write_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int GRANT_W    = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [NUM_REQ-1:0]                S_AXI_AWVALID,
  output logic [NUM_REQ-1:0]                S_AXI_AWREADY,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic [NUM_REQ-1:0]                S_AXI_WVALID,
  output logic [NUM_REQ-1:0]                S_AXI_WREADY,
  output logic [NUM_REQ*2-1:0]              S_AXI_BRESP,
  output logic [NUM_REQ-1:0]                S_AXI_BVALID,
  input  logic [NUM_REQ-1:0]                S_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]             M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]             M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]           M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic                              busy,
  output logic [GRANT_W-1:0]                grant_id
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_t;

  state_t             state, state_nxt;
  logic               aw_done, aw_done_nxt;
  logic               w_done, w_done_nxt;
  logic [GRANT_W-1:0] grant_nxt;
  logic [GRANT_W-1:0] winner;
  logic               aw_hs, w_hs;

`ifdef WR_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (S_AXI_AWVALID[i]) winner = GRANT_W'(i);
    end
  end
`else
  logic [GRANT_W-1:0] rr_ptr, rr_ptr_nxt;
  logic               found;
  int                 idx;

  // Scan upward from rr_ptr with wrap; first requester found wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && S_AXI_AWVALID[GRANT_W'(idx)]) begin
        winner = GRANT_W'(idx);
        found  = 1'b1;
      end
    end
  end
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt     = state;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    grant_nxt     = grant_id;
`ifndef WR_ARB_FIXED_PRIO_EN
    rr_ptr_nxt    = rr_ptr;
`endif
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    S_AXI_AWREADY = '0;
    S_AXI_WREADY  = '0;
    S_AXI_BRESP   = '0;
    S_AXI_BVALID  = '0;
    M_AXI_AWADDR  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (|S_AXI_AWVALID) begin
          grant_nxt = winner;
          state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == GRANT_W'(i)) begin
            M_AXI_AWVALID    = S_AXI_AWVALID[i] & ~aw_done;
            M_AXI_WVALID     = S_AXI_WVALID[i] & ~w_done;
            S_AXI_AWREADY[i] = M_AXI_AWREADY & ~aw_done;
            S_AXI_WREADY[i]  = M_AXI_WREADY & ~w_done;
            if (M_AXI_AWVALID) M_AXI_AWADDR = S_AXI_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (M_AXI_WVALID) begin
              M_AXI_WDATA = S_AXI_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
              M_AXI_WSTRB = S_AXI_WSTRB[i*STRB_W +: STRB_W];
            end
          end
        end
        aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
        w_hs  = M_AXI_WVALID & M_AXI_WREADY;
        // Move on in the very cycle the second of AW/W completes.
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = ST_RESP;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done | w_hs;
        end
      end

      ST_RESP: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == GRANT_W'(i)) begin
            M_AXI_BREADY    = S_AXI_BREADY[i];
            S_AXI_BVALID[i] = M_AXI_BVALID;
            if (M_AXI_BVALID) S_AXI_BRESP[i*2 +: 2] = M_AXI_BRESP;
          end
        end
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          state_nxt = ST_IDLE;
`ifndef WR_ARB_FIXED_PRIO_EN
          rr_ptr_nxt = (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);
`endif
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      grant_id <= '0;
`ifndef WR_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
      grant_id <= grant_nxt;
`ifndef WR_ARB_FIXED_PRIO_EN
      rr_ptr   <= rr_ptr_nxt;
`endif
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// Directed self-checking bench for axi4_lite_write_arbiter with two requesters.
module tb_axi4_lite_write_arbiter;

`ifdef WR_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] S_AXI_AWADDR;
  logic [1:0]  S_AXI_AWVALID, S_AXI_AWREADY;
  logic [63:0] S_AXI_WDATA;
  logic [7:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_WVALID, S_AXI_WREADY;
  logic [3:0]  S_AXI_BRESP;
  logic [1:0]  S_AXI_BVALID, S_AXI_BREADY;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic        busy;
  logic        grant_id;

  int vectors = 0;
  int miscompares = 0;
  int w_hs_cnt = 0;

  axi4_lite_write_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (M_AXI_WVALID && M_AXI_WREADY) w_hs_cnt <= w_hs_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_grant"},    grant_id, 0);
    check({tag, "_awready"},  S_AXI_AWREADY, 0);
    check({tag, "_wready"},   S_AXI_WREADY, 0);
    check({tag, "_bvalid"},   S_AXI_BVALID, 0);
    check({tag, "_bresp"},    S_AXI_BRESP, 0);
    check({tag, "_m_awvalid"}, M_AXI_AWVALID, 0);
    check({tag, "_m_awaddr"}, M_AXI_AWADDR, 0);
    check({tag, "_m_wvalid"}, M_AXI_WVALID, 0);
    check({tag, "_m_wdata"},  M_AXI_WDATA, 0);
    check({tag, "_m_wstrb"},  M_AXI_WSTRB, 0);
    check({tag, "_m_bready"}, M_AXI_BREADY, 0);
  endtask

  function automatic logic [1:0] onehot(input int g);
    logic [1:0] v;
    v = 2'b01;
    return v << g;
  endfunction

  function automatic int exp_sim(input int k);
    return FIXED ? 0 : k % 2;
  endfunction

  initial begin
    int wcnt0, g, other, n, nb;
    logic [31:0] req_addr [2];

    rst = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_AWVALID = 2'b11; S_AXI_WVALID = 2'b11; S_AXI_BREADY = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BRESP = '0; M_AXI_BVALID = 1'b0;

    // Reset with requests pending: everything must stay quiet.
    step(); step();
    sample();
    check_all_zero("reset");
    step();
    S_AXI_AWVALID = '0; S_AXI_WVALID = '0; rst = 1'b0;
    sample();
    check("idle_busy", busy, 0);

    // Single write from requester 1.
    step();
    S_AXI_AWADDR[63:32] = 32'h100; S_AXI_WDATA[63:32] = 32'hDEAD_BEEF; S_AXI_WSTRB[7:4] = 4'hF;
    S_AXI_AWVALID = 2'b10; S_AXI_WVALID = 2'b10; S_AXI_BREADY = 2'b10;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
    sample();
    check("sw_idle_m_awvalid", M_AXI_AWVALID, 0);
    check("sw_idle_awready", S_AXI_AWREADY, 0);
    step();
    sample();
    check("sw_m_awvalid", M_AXI_AWVALID, 1);
    check("sw_m_awaddr", M_AXI_AWADDR, 32'h100);
    check("sw_m_wdata", M_AXI_WDATA, 32'hDEAD_BEEF);
    check("sw_m_wstrb", M_AXI_WSTRB, 4'hF);
    check("sw_grant", grant_id, 1);
    check("sw_busy", busy, 1);
    check("sw_awready", S_AXI_AWREADY, 2'b10);
    check("sw_wready", S_AXI_WREADY, 2'b10);
    step();
    S_AXI_AWVALID = '0; S_AXI_WVALID = '0; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
    sample();
    check("sw_bvalid", S_AXI_BVALID, 2'b10);
    check("sw_m_bready", M_AXI_BREADY, 1);
    check("sw_resp_m_awaddr", M_AXI_AWADDR, 0);
    step();
    M_AXI_BVALID = 1'b0;
    sample();
    check("sw_done_busy", busy, 0);
    check("sw_done_grant", grant_id, 1);
    check("sw_done_bvalid", S_AXI_BVALID, 0);

    // W raised before AW; slave takes W early, AW late.
    wcnt0 = w_hs_cnt;
    S_AXI_WVALID = 2'b01; S_AXI_WDATA[31:0] = 32'h1234_5678; S_AXI_WSTRB[3:0] = 4'h3;
    S_AXI_AWADDR[31:0] = 32'h200; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b1; S_AXI_BREADY = 2'b01;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("wfirst_idle_busy", busy, 0);
      check("wfirst_idle_m_wvalid", M_AXI_WVALID, 0);
      check("wfirst_idle_wready", S_AXI_WREADY, 0);
      step();
    end
    S_AXI_AWVALID = 2'b01;
    step();
    sample();
    check("wfirst_grant", grant_id, 0);
    check("wfirst_m_wvalid", M_AXI_WVALID, 1);
    check("wfirst_wready", S_AXI_WREADY, 2'b01);
    check("wfirst_awready", S_AXI_AWREADY, 2'b00);
    check("wfirst_m_wdata", M_AXI_WDATA, 32'h1234_5678);
    step();
    sample();
    check("wfirst_wdone_m_wvalid", M_AXI_WVALID, 0);
    check("wfirst_wdone_wready", S_AXI_WREADY, 0);
    check("wfirst_wdone_m_wdata", M_AXI_WDATA, 0);
    check("wfirst_wdone_m_awvalid", M_AXI_AWVALID, 1);
    step();
    sample();
    check("wfirst_hold_m_wvalid", M_AXI_WVALID, 0);
    step();
    M_AXI_AWREADY = 1'b1;
    sample();
    check("wfirst_awready_late", S_AXI_AWREADY, 2'b01);
    step();
    S_AXI_AWVALID = '0; S_AXI_WVALID = '0; M_AXI_BVALID = 1'b1;
    sample();
    check("wfirst_resp_busy", busy, 1);
    check("wfirst_resp_bvalid", S_AXI_BVALID, 2'b01);
    step();
    M_AXI_BVALID = 1'b0;
    sample();
    check("wfirst_done_busy", busy, 0);
    check("wfirst_w_handshakes", w_hs_cnt - wcnt0, 1);

    // B backpressure with the other master waiting.
    g = FIXED ? 0 : 1;
    other = 1 - g;
    req_addr[0] = 32'h400; req_addr[1] = 32'h300;
    S_AXI_AWADDR = {req_addr[1], req_addr[0]};
    S_AXI_AWVALID = 2'b11; S_AXI_WVALID = 2'b11; S_AXI_BREADY = 2'b00;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b10;
    step();
    sample();
    check("bp_grant", grant_id, g);
    check("bp_m_awaddr", M_AXI_AWADDR, req_addr[g]);
    step();
    S_AXI_AWVALID[g] = 1'b0; S_AXI_WVALID[g] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample();
      check("bp_hold_busy", busy, 1);
      check("bp_hold_bvalid", S_AXI_BVALID, onehot(g));
      check("bp_hold_bresp", S_AXI_BRESP, 4'(2'b10) << (2 * g));
      check("bp_hold_m_bready", M_AXI_BREADY, 0);
      check("bp_hold_grant", grant_id, g);
      step();
    end
    S_AXI_BREADY = 2'b11;
    sample();
    check("bp_release_m_bready", M_AXI_BREADY, 1);
    step();
    sample();
    check("bp_idle_busy", busy, 0);
    check("bp_idle_bvalid", S_AXI_BVALID, 0);
    step();
    sample();
    check("bp_next_grant", grant_id, other);
    check("bp_next_m_awaddr", M_AXI_AWADDR, req_addr[other]);
    step();
    S_AXI_AWVALID = '0; S_AXI_WVALID = '0;
    sample();
    check("bp_next_bvalid", S_AXI_BVALID, onehot(other));
    step();
    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    sample();
    check("bp_next_done_busy", busy, 0);

    // Reset after the AW handshake, W still outstanding.
    S_AXI_AWADDR[63:32] = 32'h500; S_AXI_AWVALID = 2'b10; S_AXI_WVALID = 2'b10;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b0;
    step();
    step();
    sample();
    check("midrst_pre_busy", busy, 1);
    check("midrst_pre_m_awvalid", M_AXI_AWVALID, 0);
    check("midrst_pre_m_wvalid", M_AXI_WVALID, 1);
    step();
    rst = 1'b1;
    step();
    sample();
    check_all_zero("midrst");
    step();
    rst = 1'b0; S_AXI_AWVALID = '0; S_AXI_WVALID = '0; M_AXI_WREADY = 1'b1;
    step();
    S_AXI_AWADDR = {32'h700, 32'h600}; S_AXI_AWVALID = 2'b11; S_AXI_WVALID = 2'b11;
    step();
    sample();
    check("midrst_fresh_grant", grant_id, 0);
    check("midrst_fresh_m_awaddr", M_AXI_AWADDR, 32'h600);
    step();
    S_AXI_AWVALID = '0; S_AXI_WVALID = '0; M_AXI_BVALID = 1'b1;
    sample();
    check("midrst_fresh_bvalid", S_AXI_BVALID, 2'b01);
    step();
    M_AXI_BVALID = 1'b0;
    sample();
    check("midrst_fresh_done_busy", busy, 0);

    // Both masters requesting continuously from a clean reset.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_addr[0] = 32'h1000; req_addr[1] = 32'h2000;
    S_AXI_AWADDR = {req_addr[1], req_addr[0]};
    S_AXI_AWVALID = 2'b11; S_AXI_WVALID = 2'b11; S_AXI_BREADY = 2'b11;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
    n = 0;
    nb = 0;
    for (int c = 0; c < 40 && (n < 6 || nb < 6); c++) begin
      sample();
      if (M_AXI_AWVALID && n < 6) begin
        check("sim_grant", grant_id, exp_sim(n));
        check("sim_m_awaddr", M_AXI_AWADDR, req_addr[exp_sim(n)]);
        n++;
      end
      if (S_AXI_BVALID != 0 && nb < 6) begin
        check("sim_bvalid_route", S_AXI_BVALID, onehot(exp_sim(nb)));
        nb++;
      end
      step();
    end
    check("sim_grant_count", n, 6);
    check("sim_b_count", nb, 6);
    S_AXI_AWVALID = '0; S_AXI_WVALID = '0; M_AXI_BVALID = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4_lite_write_arbiter.md
Name: axi4_lite_write_arbiter

Overview:
- Shares one downstream AXI4-Lite write slave port (memory/peripheral write slave) between NUM_REQ upstream AXI4-Lite write masters.
- Typical upstream masters: CPU LSU and DMA/debug.
- Grants one requester per complete write transaction (AW + W + B) with round-robin fairness.
- Forwards the granted requester's channels to the downstream slave and isolates all other requesters.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; WSTRB is DATA_WIDTH/8.
- NUM_REQ, 2, number of upstream masters (legal 2..8).
- GRANT_W, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- S_AXI_AWADDR  input  NUM_REQ*ADDR_WIDTH  packed AW addresses; slice i belongs to requester i.
- S_AXI_AWVALID  input  NUM_REQ  per-requester AW valid.
- S_AXI_AWREADY  output  NUM_REQ  per-requester AW ready.
- S_AXI_WDATA  input  NUM_REQ*DATA_WIDTH  packed write data.
- S_AXI_WSTRB  input  NUM_REQ*(DATA_WIDTH/8)  packed byte strobes.
- S_AXI_WVALID  input  NUM_REQ  per-requester W valid.
- S_AXI_WREADY  output  NUM_REQ  per-requester W ready.
- S_AXI_BRESP  output  NUM_REQ*2  packed write responses.
- S_AXI_BVALID  output  NUM_REQ  per-requester B valid.
- S_AXI_BREADY  input  NUM_REQ  per-requester B ready.
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY  out/out/in, out/out/in, in/in/out  widths ADDR_WIDTH/1/1, DATA_WIDTH/DATA_WIDTH/8/1/1, 2/1/1  downstream port to the write slave.
- busy  output  1  high while a grant is held.
- grant_id  output  GRANT_W  index of the current or most recent grantee.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - state goes to ST_IDLE; rr_ptr = 0; grant_id = 0; aw_done = w_done = 0.
  - All outputs are 0: every *VALID and *READY, busy, and all data/addr/resp buses.
- ST_IDLE:
  - No forwarding takes place; all upstream READY and downstream VALID outputs are 0.
  - When any S_AXI_AWVALID[i] is high, select a winner: the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register the winner into grant_id and go to ST_ADDR.
  - WVALID without AWVALID does not trigger arbitration.
- ST_ADDR:
  - Mux the granted slice onto M_AXI_AW* and M_AXI_W*.
  - M_AXI_AWVALID = S_AXI_AWVALID[g] & ~aw_done.
  - M_AXI_WVALID = S_AXI_WVALID[g] & ~w_done.
  - S_AXI_AWREADY[g] = M_AXI_AWREADY & ~aw_done; S_AXI_WREADY[g] is analogous.
  - Non-granted requesters see READY = 0.
  - Set aw_done / w_done on the respective downstream handshake.
  - AW and W may complete in the same cycle or in either order.
  - When both are done (including the cycle in which the last one completes), clear the flags and go to ST_RESP.
- ST_RESP:
  - Route M_AXI_BVALID/BRESP to slice g only; M_AXI_BREADY = S_AXI_BREADY[g].
  - On the B handshake: rr_ptr = (g+1) mod NUM_REQ, then go to ST_IDLE.
- Latency:
  - AWVALID sampled in ST_IDLE at cycle N → M_AXI_AWVALID at cycle N+1.
  - One idle cycle between back-to-back transactions.
- busy = (state != ST_IDLE). grant_id holds its last value while in ST_IDLE.
- Downstream data/addr outputs are 0 when the corresponding VALID is 0.
- No combinational path from upstream VALID to upstream READY in ST_IDLE.
- Requester VALID dropping mid-grant (AXI violation) is ignored: the grant is held until the B handshake completes.
- Reset mid-transaction aborts immediately; the downstream slave is expected to be reset by the same rst.

Optional Feature:
- Macro WR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index wins; rr_ptr is not implemented.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single write: only requester 1 issues AW=0x100, W=0xDEADBEEF, WSTRB=0xF, slave BRESP=0 → M_AXI_AWADDR=0x100 at cycle +1; S_AXI_BVALID[1]=1 only; grant_id=1; return to idle.
- Simultaneous requests: requesters 0 and 1 both hold AWVALID continuously with three writes each → grant order 0,1,0,1,0,1; no B is ever routed to the non-granted requester.
- W before AW: granted requester raises WVALID 3 cycles before AWVALID, and the slave asserts WREADY early → w_done is held and the transaction completes exactly once, with a single M_AXI_WVALID handshake.
- B backpressure: BREADY held low for 5 cycles → BVALID stays at 1, state stays ST_RESP, and a pending request from the other master is not granted until the handshake.
- Reset mid-op: rst asserted in ST_ADDR after the AW handshake → next cycle all outputs are 0, busy=0, rr_ptr=0, and a fresh request is served normally.
- With WR_ARB_FIXED_PRIO_EN defined: requesters 0 and 1 requesting continuously → requester 0 wins every arbitration.
